// File: rtl/reg_dump_pkg.sv
// Shared constants and FSM encoding for the register-bank dump engine.
package reg_dump_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/reg_dump.sv
// Walks a wrapping index range through one bank read port and streams
// each captured word as an {index, data} beat on a valid/ready port.
module reg_dump
  import reg_dump_pkg::*;
(
  input  logic          clk,
  input  logic          reset_DUMP,
  input  logic          start,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  input  logic          abort,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] end_q;
  logic          issued_q;
  logic          valid_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          last_q;
  logic          done_q;

  logic          hs_c;
  logic          load_c;
  logic          at_end_c;
  logic [AW-1:0] ptr_inc_c;

  // Handshake / load qualifiers; the output slot refills in the same
  // cycle it drains so back-pressure never introduces a bubble.
  always_comb begin
    hs_c      = valid_q & out_ready;
    load_c    = (state_q == ST_STREAM) & ~issued_q & (~valid_q | out_ready);
    at_end_c  = (ptr_q == end_q);
    ptr_inc_c = ptr_q + AW'(1);
  end

  // Dump FSM with registered beat slot; abort outranks handshake and load.
  always_ff @(posedge clk) begin
    if (reset_DUMP) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      end_q    <= '0;
      issued_q <= 1'b0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_STREAM;
            ptr_q    <= first;
            end_q    <= last;
            issued_q <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (abort) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end else if (hs_c && last_q) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (load_c) begin
            data_q  <= rf_data;
            addr_q  <= ptr_q;
            valid_q <= 1'b1;
            last_q  <= at_end_c;
            if (at_end_c) begin
              issued_q <= 1'b1;
            end else begin
              ptr_q <= ptr_inc_c;
            end
          end else if (hs_c) begin
            valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rf_addr   = ptr_q;
  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign busy      = (state_q == ST_STREAM);
  assign done      = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: queue-based model of the expected beat stream plus
// directed scenarios with hand-computed expectations.
module tb_reg_dump;
  import reg_dump_pkg::*;

  logic          clk = 1'b0;
  logic          reset_DUMP;
  logic          start;
  logic [AW-1:0] first;
  logic [AW-1:0] last;
  logic          abort;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] bank [NREG];
  assign rf_data = bank[rf_addr];

  always #5 clk = ~clk;

  reg_dump dut (
    .clk       (clk),
    .reset_DUMP(reset_DUMP),
    .start     (start),
    .first     (first),
    .last      (last),
    .abort     (abort),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         q[$];
  bit            m_busy  = 1'b0;
  bit            m_first = 1'b0;
  bit            m_done  = 1'b0;
  bit            m_zero  = 1'b0;
  bit            m_clear = 1'b0;
  bit            checking = 1'b0;
  int            hs_count = 0;
  int            done_cyc = -1;
  logic [AW-1:0] acc_log[$];
  logic [DW-1:0] dat_log[$];

  // Expected stream: indices first..last with AW-bit wrap, words as of start.
  function automatic void build(input logic [AW-1:0] f, input logic [AW-1:0] l);
    logic [AW-1:0] span;
    logic [AW-1:0] ix;
    beat_t         b;
    span = l - f;
    q.delete();
    for (int k = 0; k <= int'(span); k++) begin
      ix  = f + AW'(k);
      b.a = ix;
      b.d = bank[ix];
      q.push_back(b);
    end
  endfunction

  // Check outputs for this cycle, then advance the model by this cycle's inputs.
  always @(negedge clk) begin
    if (checking) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("out_valid", out_valid, m_busy && !m_first);
      if (m_busy && m_first && q.size() > 0)
        chk("rf_addr_start", rf_addr, q[0].a);
      if (m_busy && !m_first && q.size() > 0) begin
        chk("out_addr", out_addr, q[0].a);
        chk("out_data", out_data, q[0].d);
        chk("out_last", out_last, q.size() == 1);
        chk("rf_addr", rf_addr, (q.size() > 1) ? q[1].a : q[0].a);
      end
      if (m_zero) begin
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
      end
      if (m_clear) chk("abort_out_last", out_last, 0);

      m_done  = 1'b0;
      m_zero  = 1'b0;
      m_clear = 1'b0;
      if (reset_DUMP) begin
        q.delete();
        m_busy  = 1'b0;
        m_first = 1'b0;
        m_zero  = 1'b1;
      end else if (m_busy) begin
        if (abort) begin
          q.delete();
          m_busy  = 1'b0;
          m_first = 1'b0;
          m_clear = 1'b1;
        end else if (m_first) begin
          m_first = 1'b0;
        end else if (out_ready && q.size() > 0) begin
          acc_log.push_back(q[0].a);
          dat_log.push_back(q[0].d);
          hs_count++;
          void'(q.pop_front());
          if (q.size() == 0) begin
            m_busy   = 1'b0;
            m_done   = 1'b1;
            done_cyc = cyc + 1;
          end
        end
      end else if (start) begin
        build(first, last);
        m_busy  = 1'b1;
        m_first = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l, output int s);
    s     = cyc;
    first = f;
    last  = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input bit rnd, input int budget);
    int n;
    n = 0;
    while (m_busy && n < budget) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_ready = 1'b1;
    if (m_busy) begin
      checks++;
      errors++;
      $display("FAIL timeout: still busy after %0d cycles", budget);
    end
  endtask

  int s;
  int h0;
  int n;
  int bad;

  initial begin
    reset_DUMP = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b1;
    first      = '0;
    last       = '0;
    for (int i = 0; i < int'(NREG); i++) bank[i] = 32'h1000_0000 + DW'(i);

    // Reset state
    tick();
    checking = 1'b1;
    tick();
    reset_DUMP = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);

    // Full dump 0..31 with ready held high
    h0 = hs_count; acc_log.delete(); dat_log.delete();
    do_start(5'd0, 5'd31, s);
    run_until_idle(1'b0, 100);
    chk("full_beats", hs_count - h0, 32);
    chk("full_done_cycle", done_cyc - s, 34);
    chk("full_last_idx", acc_log[31], 31);
    chk("full_data5", dat_log[5], 32'h1000_0005);

    // Wrap 30..1, started in the done cycle of the previous dump
    h0 = hs_count; acc_log.delete(); dat_log.delete();
    do_start(5'd30, 5'd1, s);
    run_until_idle(1'b0, 50);
    chk("wrap_beats", hs_count - h0, 4);
    chk("wrap_idx0", acc_log[0], 30);
    chk("wrap_idx1", acc_log[1], 31);
    chk("wrap_idx2", acc_log[2], 0);
    chk("wrap_idx3", acc_log[3], 1);

    // Single beat
    bank[7] = 32'hDEAD_BEEF;
    tick();
    h0 = hs_count; acc_log.delete(); dat_log.delete();
    do_start(5'd7, 5'd7, s);
    run_until_idle(1'b0, 20);
    chk("single_beats", hs_count - h0, 1);
    chk("single_data", dat_log[0], 32'hDEAD_BEEF);
    chk("single_done_cycle", done_cyc - s, 3);

    // Random back-pressure over the full range
    h0 = hs_count; acc_log.delete(); dat_log.delete();
    do_start(5'd0, 5'd31, s);
    run_until_idle(1'b1, 1000);
    chk("bp_beats", hs_count - h0, 32);
    bad = 0;
    for (int i = 0; i < 32; i++) if (acc_log[i] !== 5'(i)) bad++;
    chk("bp_order_errors", bad, 0);
    chk("bp_data31", dat_log[31], 32'h1000_001F);

    // Abort after the third beat, then a fresh dump
    h0 = hs_count; acc_log.delete();
    do_start(5'd0, 5'd31, s);
    n = 0;
    while (hs_count - h0 < 3 && n < 100) begin tick(); n++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_beats", hs_count - h0, 3);
    tick();
    h0 = hs_count; acc_log.delete();
    do_start(5'd2, 5'd4, s);
    run_until_idle(1'b0, 50);
    chk("post_abort_beats", hs_count - h0, 3);
    chk("post_abort_idx0", acc_log[0], 2);

    // Reset mid-stream
    tick();
    do_start(5'd0, 5'd31, s);
    repeat (5) tick();
    reset_DUMP = 1'b1;
    tick();
    reset_DUMP = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    tick();

    // Snapshot: overwrite reg[20] once its beat is loaded; stray start ignored
    h0 = hs_count; acc_log.delete(); dat_log.delete();
    do_start(5'd16, 5'd24, s);
    n = 0;
    while (!(out_valid && out_addr == 5'd20) && n < 50) begin tick(); n++; end
    bank[20] = 32'hBAD0_0020;
    do_start(5'd3, 5'd3, n);
    run_until_idle(1'b0, 50);
    chk("snap_beats", hs_count - h0, 9);
    chk("snap_idx4", acc_log[4], 20);
    chk("snap_data20", dat_log[4], 32'h1000_0014);
    chk("snap_idx8", acc_log[8], 24);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
